// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable up/down counter: end-of-range modes
// and the elaboration-time parameter legality check.
package prog_counter_pkg;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;
    localparam int unsigned MODE_ONESHOT  = 2;

    // True when the numeric parameter set describes a buildable counter.
    function automatic bit params_legal(
        input int unsigned data_width,
        input int unsigned count_from,
        input int unsigned count_to,
        input int unsigned step,
        input int unsigned mode
    );
        longint unsigned limit;
        if (data_width < 2 || data_width > 32) return 1'b0;
        limit = longint'(1) << data_width;
        if (count_from >= count_to) return 1'b0;
        if (longint'(count_to) >= limit) return 1'b0;
        if (step < 1 || step > (count_to - count_from)) return 1'b0;
        if (mode > MODE_ONESHOT) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/prog_counter_step.sv
// Combinational step unit: proposes the next count and flags a range crossing.
// Arithmetic is one bit wider than the count so an upward step cannot wrap.
module prog_counter_step
    import prog_counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COUNT_FROM = 0,
    parameter int unsigned COUNT_TO   = 255,
    parameter int unsigned STEP       = 1
) (
    input  logic [DATA_WIDTH-1:0] cnt_i,
    input  logic                  dir_i,
    output logic [DATA_WIDTH-1:0] nxt_o,
    output logic                  cross_o
);

    localparam logic [DATA_WIDTH:0] STEP_X      = (DATA_WIDTH+1)'(STEP);
    localparam logic [DATA_WIDTH:0] FROM_X      = (DATA_WIDTH+1)'(COUNT_FROM);
    localparam logic [DATA_WIDTH:0] TO_X        = (DATA_WIDTH+1)'(COUNT_TO);
    localparam logic [DATA_WIDTH:0] DOWN_LIMIT  = FROM_X + STEP_X;

    logic [DATA_WIDTH:0] cnt_x;
    logic [DATA_WIDTH:0] up_sum;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        cnt_x   = {1'b0, cnt_i};
        up_sum  = cnt_x + STEP_X;
        nxt_o   = cnt_i;
        cross_o = 1'b0;
        if (dir_i) begin
            cross_o = (up_sum > TO_X);
            nxt_o   = up_sum[DATA_WIDTH-1:0];
        end else begin
            // Compare before subtracting so the down step never underflows.
            cross_o = (cnt_x < DOWN_LIMIT);
            nxt_o   = cnt_i - STEP_X[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Parametrised up/down counter with programmable bounds, step and end-of-range
// behaviour (wrap, saturate or one-shot), runtime load and terminal-count pulse.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter string       BLOCK_NAME   = "prog_counter",
    parameter int          X            = 0,
    parameter int          Y            = 0,
    parameter int          DX           = 0,
    parameter int          DY           = 0,
    parameter string       ARCHITECTURE = "BEHAVIORAL",
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned COUNT_FROM   = 0,
    parameter int unsigned COUNT_TO     = 255,
    parameter int unsigned STEP         = 1,
    parameter int unsigned MODE         = MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  tc,
    output logic                  done
);

    if (ARCHITECTURE != "BEHAVIORAL") begin : g_bad_arch
        $error("%s at (%0d,%0d,%0d,%0d): unsupported ARCHITECTURE", BLOCK_NAME, X, Y, DX, DY);
    end

    if (!params_legal(DATA_WIDTH, COUNT_FROM, COUNT_TO, STEP, MODE)) begin : g_bad_params
        $error("%s: illegal DATA_WIDTH/COUNT_FROM/COUNT_TO/STEP/MODE combination", BLOCK_NAME);
    end

    localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);
    localparam logic [DATA_WIDTH-1:0] TO_V   = DATA_WIDTH'(COUNT_TO);

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  tc_q, tc_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] step_nxt;
    logic                  step_cross;
    logic [DATA_WIDTH-1:0] term_val;
    logic [DATA_WIDTH-1:0] wrap_val;
    logic [DATA_WIDTH-1:0] load_clamped;

    prog_counter_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_FROM (COUNT_FROM),
        .COUNT_TO   (COUNT_TO),
        .STEP       (STEP)
    ) u_step (
        .cnt_i   (out_q),
        .dir_i   (dir),
        .nxt_o   (step_nxt),
        .cross_o (step_cross)
    );

    // Direction is used live, so a dir flip retargets the bounds on the same edge.
    always_comb begin
        term_val = dir ? TO_V : FROM_V;
        wrap_val = dir ? FROM_V : TO_V;
        if (load_val < FROM_V) begin
            load_clamped = FROM_V;
        end else if (load_val > TO_V) begin
            load_clamped = TO_V;
        end else begin
            load_clamped = load_val;
        end
    end

    always_comb begin
        out_d  = out_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (load) begin
            out_d  = load_clamped;
            done_d = 1'b0;
        end else if (en && !done_q) begin
            if (!step_cross) begin
                out_d = step_nxt;
            end else begin
                case (MODE)
                    MODE_SATURATE: begin
                        // Sitting at the terminal value already: no new pulse.
                        out_d = term_val;
                        tc_d  = (out_q != term_val);
                    end
                    MODE_ONESHOT: begin
                        out_d  = term_val;
                        tc_d   = 1'b1;
                        done_d = 1'b1;
                    end
                    default: begin
                        out_d = wrap_val;
                        tc_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q  <= FROM_V;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule
